traffic_conflict_monitor: RTL and testbench

- Independent safety monitor on the lamp side of the signal interface. It samples the 16 lamp drives (main road A, side road B) that the traffic light controller produces.
- It detects unsafe lamp patterns: green/green conflict, head mismatch, dark approach, and short or skipped yellow.
- On detection it latches a fault code, counts the fault, and raises a flash-override request until an operator clear is accepted.
- Sits between the controller lamp outputs and the lamp drivers/LCD status path.

---
 rtl/traffic_conflict_monitor.sv | 252 +++++++++++++++++++++++++
 tb/tb_traffic_conflict_monitor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_conflict_monitor.sv
`default_nettype none
// ============================================================================
// Module   : traffic_conflict_monitor
// Function : Independent lamp-side safety monitor. Watches the 16 lamp drives
//            of a two-approach intersection for green/green conflicts, head
//            mismatches, dark approaches and short/skipped yellow. On a trip
//            it latches a fault code, counts the event and drives a flash
//            override until an operator clear is accepted.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_conflict_monitor #(
  parameter int PERSIST_CYC    = 4,
  parameter int MIN_YELLOW_CYC = 150,
  parameter int STARTUP_CYC    = 8,
  parameter int FLASH_CYC      = 25
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] a_lamps,
  input  logic [7:0] b_lamps,
  input  logic       clear,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] fault_appr,
  output logic       flash_out,
  output logic [7:0] fault_cnt
);

  localparam int PW = $clog2(PERSIST_CYC + 1);
  localparam int YW = $clog2(MIN_YELLOW_CYC + 1);
  localparam int SW = $clog2(STARTUP_CYC + 1);
  localparam int FW = $clog2(FLASH_CYC + 1);

  localparam logic [PW-1:0] P_MAX  = PW'(PERSIST_CYC);
  localparam logic [PW-1:0] P_LAST = PW'(PERSIST_CYC - 1);
  localparam logic [YW-1:0] Y_MIN  = YW'(MIN_YELLOW_CYC);
  localparam logic [SW-1:0] S_LAST = SW'(STARTUP_CYC - 1);
  localparam logic [FW-1:0] F_LAST = FW'(FLASH_CYC - 1);

  localparam logic [2:0] CODE_NONE     = 3'd0;
  localparam logic [2:0] CODE_CONFLICT = 3'd1;
  localparam logic [2:0] CODE_MISMATCH = 3'd2;
  localparam logic [2:0] CODE_DARK     = 3'd3;
  localparam logic [2:0] CODE_SHORT_Y  = 3'd4;

  typedef enum logic [1:0] {
    STARTUP = 2'd0,
    MONITOR = 2'd1,
    FAULT   = 2'd2
  } state_t;

  state_t state, state_nx;

  // Index 0 is approach A, index 1 is approach B throughout.
  logic [1:0][7:0] lamps;
  logic [1:0]      grn, yel, red, mism, dark, short_ev;
  logic            conflict, any_mism, any_dark;
  logic            checking, clr_accept, cnt_hold;

  logic [PW-1:0]   conf_cnt, mism_cnt, dark_cnt;
  logic            trip_conf, trip_mism, trip_dark, trip_short;
  logic [2:0]      win_code;
  logic [1:0]      win_appr;

  logic [SW-1:0]   start_cnt, start_cnt_nx;
  logic [FW-1:0]   flash_cnt, flash_cnt_nx;
  logic            fault_nx, flash_nx;
  logic [2:0]      code_nx;
  logic [1:0]      appr_nx;
  logic [7:0]      fcnt_nx;

  assign lamps      = {b_lamps, a_lamps};
  assign conflict   = grn[0] & grn[1];
  assign any_mism   = |mism;
  assign any_dark   = |dark;
  assign checking   = (state != STARTUP);
  // A clear is honoured only once every level condition has gone away.
  assign clr_accept = (state == FAULT) & clear & ~(conflict | any_mism | any_dark);
  assign cnt_hold   = ~checking | clr_accept;

  generate
    for (genvar i = 0; i < 2; i++) begin : g_appr
      logic [YW-1:0] yrun;
      logic          prev_grn;
      logic          prev_yel;

      // Lamp bit order: G1 G2 GL1 GL2 Y1 Y2 R1 R2 (MSB first)
      assign grn[i]  = |lamps[i][7:4];
      assign yel[i]  = |lamps[i][3:2];
      assign red[i]  = |lamps[i][1:0];
      assign mism[i] = (lamps[i][7] ^ lamps[i][6]) | (lamps[i][5] ^ lamps[i][4]) |
                       (lamps[i][3] ^ lamps[i][2]) | (lamps[i][1] ^ lamps[i][0]);
      assign dark[i] = ~(grn[i] | yel[i] | red[i]);

      // Entering red straight after a too-short yellow, or straight from green.
      // Yellow back to green (controller abort) is deliberately not flagged.
      assign short_ev[i] = red[i] & ~yel[i] &
                           ((prev_yel & (yrun < Y_MIN)) | (prev_grn & ~grn[i]));

      // Lamp history follows the inputs at all times, including startup
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          prev_grn <= 1'b0;
          prev_yel <= 1'b0;
        end else begin
          prev_grn <= grn[i];
          prev_yel <= yel[i];
        end
      end

      // Length of the current yellow run, saturating at the legal minimum
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          yrun <= '0;
        end else if (cnt_hold || !yel[i]) begin
          yrun <= '0;
        end else if (yrun != Y_MIN) begin
          yrun <= yrun + YW'(1);
        end
      end
    end
  endgenerate

  function automatic logic [PW-1:0] pnext(input logic raw, input logic [PW-1:0] cnt);
    if (!raw) begin
      return '0;
    end else if (cnt == P_MAX) begin
      return P_MAX;
    end
    return cnt + PW'(1);
  endfunction

  // Persistence counters: consecutive sampled-high edges per condition class
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      conf_cnt <= '0;
      mism_cnt <= '0;
      dark_cnt <= '0;
    end else if (cnt_hold) begin
      conf_cnt <= '0;
      mism_cnt <= '0;
      dark_cnt <= '0;
    end else begin
      conf_cnt <= pnext(conflict, conf_cnt);
      mism_cnt <= pnext(any_mism, mism_cnt);
      dark_cnt <= pnext(any_dark, dark_cnt);
    end
  end

  // A class trips on the edge that carries its counter up to the threshold.
  assign trip_conf  = conflict & (conf_cnt == P_LAST);
  assign trip_mism  = any_mism & (mism_cnt == P_LAST);
  assign trip_dark  = any_dark & (dark_cnt == P_LAST);
  assign trip_short = |short_ev;

  // Priority select of the winning fault class and the approaches involved
  always_comb begin
    win_code = CODE_NONE;
    win_appr = 2'b00;
    if (trip_conf) begin
      win_code = CODE_CONFLICT;
      win_appr = 2'b11;
    end else if (trip_dark) begin
      win_code = CODE_DARK;
      win_appr = dark;
    end else if (trip_mism) begin
      win_code = CODE_MISMATCH;
      win_appr = mism;
    end else if (trip_short) begin
      win_code = CODE_SHORT_Y;
      win_appr = short_ev;
    end
  end

  // State register and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= STARTUP;
      start_cnt  <= '0;
      flash_cnt  <= '0;
      fault      <= 1'b0;
      fault_code <= CODE_NONE;
      fault_appr <= 2'b00;
      flash_out  <= 1'b0;
      fault_cnt  <= 8'd0;
    end else begin
      state      <= state_nx;
      start_cnt  <= start_cnt_nx;
      flash_cnt  <= flash_cnt_nx;
      fault      <= fault_nx;
      fault_code <= code_nx;
      fault_appr <= appr_nx;
      flash_out  <= flash_nx;
      fault_cnt  <= fcnt_nx;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx     = state;
    start_cnt_nx = start_cnt;
    flash_cnt_nx = flash_cnt;
    fault_nx     = fault;
    code_nx      = fault_code;
    appr_nx      = fault_appr;
    flash_nx     = flash_out;
    fcnt_nx      = fault_cnt;
    case (state)
      STARTUP: begin
        if (start_cnt == S_LAST) begin
          state_nx     = MONITOR;
          start_cnt_nx = '0;
        end else begin
          start_cnt_nx = start_cnt + SW'(1);
        end
      end
      MONITOR: begin
        if (win_code != CODE_NONE) begin
          state_nx     = FAULT;
          fault_nx     = 1'b1;
          code_nx      = win_code;
          appr_nx      = win_appr;
          flash_nx     = 1'b1;
          flash_cnt_nx = '0;
          if (fault_cnt != 8'hFF) begin
            fcnt_nx = fault_cnt + 8'd1;
          end
        end
      end
      FAULT: begin
        if (clr_accept) begin
          state_nx     = MONITOR;
          fault_nx     = 1'b0;
          code_nx      = CODE_NONE;
          appr_nx      = 2'b00;
          flash_nx     = 1'b0;
          flash_cnt_nx = '0;
        end else if (flash_cnt == F_LAST) begin
          flash_nx     = ~flash_out;
          flash_cnt_nx = '0;
        end else begin
          flash_cnt_nx = flash_cnt + FW'(1);
        end
      end
      default: begin
        state_nx = STARTUP;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_traffic_conflict_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_conflict_monitor
// Function : Directed self-checking bench for traffic_conflict_monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_conflict_monitor;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] a_lamps;
  logic [7:0] b_lamps;
  logic       clear;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] fault_appr;
  logic       flash_out;
  logic [7:0] fault_cnt;

  int tests = 0;
  int fails = 0;
  int bad   = 0;

  // 10 time-unit clock
  always #5 clk = ~clk;

  traffic_conflict_monitor dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .a_lamps    (a_lamps),
    .b_lamps    (b_lamps),
    .clear      (clear),
    .fault      (fault),
    .fault_code (fault_code),
    .fault_appr (fault_appr),
    .flash_out  (flash_out),
    .fault_cnt  (fault_cnt)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_fault(input string tag, input logic [2:0] code,
                           input logic [1:0] appr, input logic [7:0] cnt);
    chk({tag, "_fault"}, 32'(fault), 32'd1);
    chk({tag, "_code"},  32'(fault_code), 32'(code));
    chk({tag, "_appr"},  32'(fault_appr), 32'(appr));
    chk({tag, "_cnt"},   32'(fault_cnt), 32'(cnt));
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  initial begin
    reset_n = 1'b1;
    clear   = 1'b0;
    a_lamps = 8'hF0;
    b_lamps = 8'h03;
    #2 reset_n = 1'b0;
    step(3);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_code",  32'(fault_code), 32'd0);
    chk("rst_appr",  32'(fault_appr), 32'd0);
    chk("rst_flash", 32'(flash_out), 32'd0);
    chk("rst_cnt",   32'(fault_cnt), 32'd0);
    reset_n = 1'b1;

    // Legal A green / B red held for 500 cycles: nothing may trip
    for (int i = 0; i < 500; i++) begin
      step(1);
      if (fault !== 1'b0 || fault_cnt !== 8'd0 || flash_out !== 1'b0) bad++;
    end
    chk("legal_hold", 32'(bad), 32'd0);

    // Conflict for only 3 cycles, then B yellow for a full 150 cycles, then red
    b_lamps = 8'hC0;
    step(3);
    chk("conf3_nofault", 32'(fault), 32'd0);
    b_lamps = 8'h0C;
    step(150);
    b_lamps = 8'h03;
    step(2);
    chk("yel150_b_nofault", 32'(fault), 32'd0);

    // B red -> green gives a conflict that persists: trips on the 4th edge
    b_lamps = 8'hC0;
    step(3);
    chk("conf_pre_trip", 32'(fault), 32'd0);
    step(1);
    chk_fault("conflict", 3'd1, 2'b11, 8'd1);
    chk("flash_entry", 32'(flash_out), 32'd1);
    step(24);
    chk("flash_hold24", 32'(flash_out), 32'd1);
    step(1);
    chk("flash_toggle25", 32'(flash_out), 32'd0);
    step(25);
    chk("flash_toggle50", 32'(flash_out), 32'd1);

    // Clear while the conflict persists is ignored
    pulse_clear();
    chk("clr_ignored_fault", 32'(fault), 32'd1);
    chk("clr_ignored_code",  32'(fault_code), 32'd1);

    // Remove the conflict, then clear is accepted
    b_lamps = 8'h03;
    step(1);
    pulse_clear();
    chk("clr_fault", 32'(fault), 32'd0);
    chk("clr_code",  32'(fault_code), 32'd0);
    chk("clr_appr",  32'(fault_appr), 32'd0);
    chk("clr_flash", 32'(flash_out), 32'd0);
    chk("clr_cnt_kept", 32'(fault_cnt), 32'd1);

    // A yellow only 100 cycles then red: short yellow
    a_lamps = 8'h0C;
    step(100);
    a_lamps = 8'h03;
    step(1);
    chk_fault("short_y100", 3'd4, 2'b01, 8'd2);
    pulse_clear();
    chk("short_y_clr", 32'(fault), 32'd0);

    // A green, then exactly 150 cycles of yellow, then red: legal
    a_lamps = 8'hF0;
    step(2);
    a_lamps = 8'h0C;
    step(150);
    a_lamps = 8'h03;
    step(2);
    chk("yel150_a_nofault", 32'(fault), 32'd0);

    // A green straight to red: skipped yellow
    a_lamps = 8'hC0;
    step(2);
    a_lamps = 8'h03;
    step(1);
    chk_fault("skip_yel", 3'd4, 2'b01, 8'd3);
    pulse_clear();

    // A head mismatch (AY1 only)
    a_lamps = 8'h08;
    step(3);
    chk("mism_pre_trip", 32'(fault), 32'd0);
    step(1);
    chk_fault("mismatch", 3'd2, 2'b01, 8'd4);
    a_lamps = 8'h03;
    step(1);
    pulse_clear();
    chk("mism_clr", 32'(fault), 32'd0);

    // B dark
    b_lamps = 8'h00;
    step(3);
    chk("dark_pre_trip", 32'(fault), 32'd0);
    step(1);
    chk_fault("dark", 3'd3, 2'b10, 8'd5);
    b_lamps = 8'h03;
    step(1);
    pulse_clear();

    // A dark and B mismatch on the same edge: dark wins, only A reported
    a_lamps = 8'h00;
    b_lamps = 8'h08;
    step(4);
    chk_fault("dark_over_mism", 3'd3, 2'b01, 8'd6);
    a_lamps = 8'h03;
    b_lamps = 8'h03;
    step(1);
    pulse_clear();

    // Conflict and B mismatch on the same edge: conflict wins
    a_lamps = 8'hC0;
    b_lamps = 8'h80;
    step(4);
    chk_fault("conf_over_mism", 3'd1, 2'b11, 8'd7);
    a_lamps = 8'h03;
    b_lamps = 8'h03;
    step(1);
    pulse_clear();
    chk("prio_clr", 32'(fault), 32'd0);

    // Repeated trip/clear to drive the counter to its ceiling
    a_lamps = 8'hF0;
    for (int i = 0; i < 248; i++) begin
      b_lamps = 8'hC0;
      step(4);
      b_lamps = 8'h03;
      step(1);
      pulse_clear();
    end
    chk("cnt_at_255", 32'(fault_cnt), 32'd255);
    chk("cnt_at_255_idle", 32'(fault), 32'd0);
    b_lamps = 8'hC0;
    step(4);
    chk_fault("cnt_saturate", 3'd1, 2'b11, 8'd255);

    // Asynchronous reset in the middle of FAULT
    #3 reset_n = 1'b0;
    #1;
    chk("async_rst_fault", 32'(fault), 32'd0);
    chk("async_rst_code",  32'(fault_code), 32'd0);
    chk("async_rst_appr",  32'(fault_appr), 32'd0);
    chk("async_rst_flash", 32'(flash_out), 32'd0);
    chk("async_rst_cnt",   32'(fault_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
